// File: rtl/dtc_seq_eval.sv
// dtc_seq_eval: programmable decision-tree classifier that walks one tree level per clock.
// Optional macro DTC_SEQ_PATHLEN_EN adds out_depth, the level at which the walk stopped.
module dtc_seq_eval #(
    parameter int N_FEAT  = 8,
    parameter int DEPTH   = 4,
    parameter int CLASS_W = 1,
    localparam int FIDX_W  = (N_FEAT > 1) ? $clog2(N_FEAT) : 1,
    localparam int N_NODES = (1 << (DEPTH + 1)) - 1,
    localparam int ADDR_W  = $clog2(N_NODES),
    localparam int ENT_W   = 1 + FIDX_W + CLASS_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cfg_we,
    input  logic [ADDR_W-1:0]  cfg_addr,
    input  logic [ENT_W-1:0]   cfg_wdata,
    output logic               cfg_err,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [N_FEAT-1:0]  inp,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [CLASS_W-1:0] outp
`ifdef DTC_SEQ_PATHLEN_EN
    ,
    output logic [$clog2(DEPTH+1)-1:0] out_depth
`endif
);

    localparam int NODE_W = ADDR_W + 1;
    localparam logic [NODE_W-1:0] LAST_LVL = NODE_W'((1 << DEPTH) - 1);
    localparam logic [ENT_W-1:0]  RST_ENT  = {1'b1, {(ENT_W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, WALK, DONE} state_t;

    state_t             state;
    logic [ENT_W-1:0]   node_tbl [N_NODES];
    logic [N_FEAT-1:0]  feat;
    logic [NODE_W-1:0]  node;
    logic [ENT_W-1:0]   cur_ent;
    logic               cur_leaf;
    logic [FIDX_W-1:0]  cur_fidx;
    logic [CLASS_W-1:0] cur_cls;
    logic               bit_sel;
    logic               stop;
    logic [NODE_W-1:0]  child;
    logic               cfg_ok;

    assign cfg_ok = cfg_we && (state == IDLE) && (int'(cfg_addr) < N_NODES);

    always_comb begin
        cur_ent  = node_tbl[node[ADDR_W-1:0]];
        cur_leaf = cur_ent[ENT_W-1];
        cur_fidx = cur_ent[CLASS_W +: FIDX_W];
        cur_cls  = cur_ent[CLASS_W-1:0];
        stop     = cur_leaf || (node >= LAST_LVL);
        child    = {node[NODE_W-2:0], 1'b0} + NODE_W'(1) + NODE_W'(bit_sel);
    end

    // Feature indices beyond the vector read as 0; only needed when N_FEAT is not a power of two.
    generate
        if (N_FEAT < (1 << FIDX_W)) begin : g_fidx_guard
            assign bit_sel = (int'(cur_fidx) < N_FEAT) ? feat[cur_fidx] : 1'b0;
        end else begin : g_fidx_full
            assign bit_sel = feat[cur_fidx];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_NODES; i++)
                node_tbl[i] <= RST_ENT;
            cfg_err <= 1'b0;
        end else begin
            if (cfg_ok)
                node_tbl[cfg_addr] <= cfg_wdata;
            cfg_err <= cfg_we && !cfg_ok;
        end
    end

`ifdef DTC_SEQ_PATHLEN_EN
    localparam int DEPTH_W = $clog2(DEPTH + 1);
    logic [DEPTH_W-1:0] level;
`endif

    // DONE never hands straight over to a new accept; a fresh vector always waits for IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            outp      <= '0;
            node      <= '0;
            feat      <= '0;
`ifdef DTC_SEQ_PATHLEN_EN
            level     <= '0;
            out_depth <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        feat     <= inp;
                        node     <= '0;
                        in_ready <= 1'b0;
                        state    <= WALK;
`ifdef DTC_SEQ_PATHLEN_EN
                        level    <= '0;
`endif
                    end
                end
                WALK: begin
                    if (stop) begin
                        outp      <= cur_cls;
                        out_valid <= 1'b1;
                        state     <= DONE;
`ifdef DTC_SEQ_PATHLEN_EN
                        out_depth <= level;
`endif
                    end else begin
                        node  <= child;
`ifdef DTC_SEQ_PATHLEN_EN
                        level <= level + DEPTH_W'(1);
`endif
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dtc_seq_eval.sv
// Bench for dtc_seq_eval: a transaction-level tree model checked every cycle, plus directed literals.
// Also covers out_depth when DTC_SEQ_PATHLEN_EN is defined.
module tb_dtc_seq_eval;

    localparam int DEPTH_P = 4;
    localparam int NN      = 31;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cfg_we;
    logic [4:0] cfg_addr;
    logic [4:0] cfg_wdata;
    logic       cfg_err;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] inp;
    logic       out_valid;
    logic       out_ready;
    logic [0:0] outp;
`ifdef DTC_SEQ_PATHLEN_EN
    logic [2:0] out_depth;
`endif

    int checkCount = 0;
    int passCount  = 0;

    dtc_seq_eval dut (
        .clk(clk),
        .rst_n(rst_n),
        .cfg_we(cfg_we),
        .cfg_addr(cfg_addr),
        .cfg_wdata(cfg_wdata),
        .cfg_err(cfg_err),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .inp(inp),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .outp(outp)
`ifdef DTC_SEQ_PATHLEN_EN
        ,
        .out_depth(out_depth)
`endif
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checkCount++;
        if (actual == expected)
            passCount++;
        else
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    endtask

    function automatic logic [4:0] mk(input int leaf, input int fidx, input int cls);
        return {leaf[0], fidx[2:0], cls[0]};
    endfunction

    // Model state: the table contents plus a countdown until the result appears.
    logic [4:0] m_tbl [NN];
    logic       m_in_ready  = 1'b1;
    logic       m_out_valid = 1'b0;
    int         m_outp      = 0;
    int         m_depth     = 0;
    logic       m_err       = 1'b0;
    int         m_cnt       = 0;
    int         m_pendCls   = 0;
    int         m_pendDepth = 0;
    logic       wrOk;

    assign wrOk = cfg_we && m_in_ready && (int'(cfg_addr) < NN);

    // Walks the tree by depth count; returns depth*2 + class.
    function automatic int classify(input logic [7:0] f, input logic wr,
                                    input logic [4:0] wa, input logic [4:0] wd);
        logic [4:0] tbl [NN];
        logic [4:0] e;
        int n;
        int res;
        for (int i = 0; i < NN; i++)
            tbl[i] = m_tbl[i];
        if (wr)
            tbl[wa] = wd;
        n   = 0;
        res = 0;
        for (int lvl = 0; lvl <= DEPTH_P; lvl++) begin
            e = tbl[n];
            if (e[4] || lvl == DEPTH_P) begin
                res = lvl * 2 + int'(e[0]);
                break;
            end
            n = 2 * n + 1 + int'(f[e[3:1]]);
        end
        return res;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NN; i++)
                m_tbl[i] <= 5'b10000;
            m_in_ready  <= 1'b1;
            m_out_valid <= 1'b0;
            m_outp      <= 0;
            m_depth     <= 0;
            m_err       <= 1'b0;
            m_cnt       <= 0;
            m_pendCls   <= 0;
            m_pendDepth <= 0;
        end else begin
            m_err <= cfg_we && !wrOk;
            if (wrOk)
                m_tbl[cfg_addr] <= cfg_wdata;
            if (m_in_ready) begin
                if (in_valid) begin
                    m_pendCls   <= classify(inp, wrOk, cfg_addr, cfg_wdata) % 2;
                    m_pendDepth <= classify(inp, wrOk, cfg_addr, cfg_wdata) / 2;
                    m_cnt       <= classify(inp, wrOk, cfg_addr, cfg_wdata) / 2 + 1;
                    m_in_ready  <= 1'b0;
                end
            end else if (m_out_valid) begin
                if (out_ready) begin
                    m_out_valid <= 1'b0;
                    m_in_ready  <= 1'b1;
                end
            end else begin
                m_cnt <= m_cnt - 1;
                if (m_cnt == 1) begin
                    m_out_valid <= 1'b1;
                    m_outp      <= m_pendCls;
                    m_depth     <= m_pendDepth;
                end
            end
        end
    end

    always @(negedge clk) begin
        checkOutput("in_ready", int'(in_ready), int'(m_in_ready));
        checkOutput("out_valid", int'(out_valid), int'(m_out_valid));
        checkOutput("cfg_err", int'(cfg_err), int'(m_err));
        if (m_out_valid) begin
            checkOutput("outp", int'(outp), m_outp);
`ifdef DTC_SEQ_PATHLEN_EN
            checkOutput("out_depth", int'(out_depth), m_depth);
`endif
        end
    end

    task automatic cfgWrite(input int addr, input logic [4:0] data);
        cfg_we    = 1'b1;
        cfg_addr  = addr[4:0];
        cfg_wdata = data;
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    task automatic waitValid(output int lat);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        checkOutput("valid_seen", int'(out_valid), 1);
    endtask

    // Sends one vector, scrambles inp after acceptance, and returns latency, class and depth.
    task automatic applyStimulus(input logic [7:0] v, output int lat, output int res, output int dep);
        int guard = 0;
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        in_valid = 1'b1;
        inp      = v;
        @(negedge clk);
        in_valid = 1'b0;
        inp      = ~v;
        waitValid(lat);
        res = int'(outp);
        dep = 0;
`ifdef DTC_SEQ_PATHLEN_EN
        dep = int'(out_depth);
`endif
        @(negedge clk);
    endtask

    task automatic checkDepth(input string name, input int dep, input int expected);
`ifdef DTC_SEQ_PATHLEN_EN
        checkOutput(name, dep, expected);
`endif
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int lat, res, dep;
        rst_n = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
        in_valid = 1'b0; inp = '0; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("rst_in_ready", int'(in_ready), 1);
        checkOutput("rst_out_valid", int'(out_valid), 0);
        checkOutput("rst_outp", int'(outp), 0);
        checkOutput("rst_cfg_err", int'(cfg_err), 0);
        rst_n = 1'b1;

        applyStimulus(8'hFF, lat, res, dep);
        checkOutput("unloaded_lat", lat, 1);
        checkOutput("unloaded_outp", res, 0);
        checkDepth("unloaded_depth", dep, 0);

        cfgWrite(0, mk(0, 0, 0));
        cfgWrite(1, mk(1, 0, 0));
        cfgWrite(2, mk(1, 0, 1));
        applyStimulus(8'h01, lat, res, dep);
        checkOutput("small_01_lat", lat, 2);
        checkOutput("small_01_outp", res, 1);
        checkDepth("small_01_depth", dep, 1);
        applyStimulus(8'h00, lat, res, dep);
        checkOutput("small_00_lat", lat, 2);
        checkOutput("small_00_outp", res, 0);

        // Full-depth tree; bottom entries keep leaf=0 so the last level must stop on its own.
        for (int i = 0; i < 15; i++)
            cfgWrite(i, mk(0, 7, 0));
        for (int i = 15; i < NN; i++)
            cfgWrite(i, mk(0, 0, (i - 15) % 2));
        applyStimulus(8'h80, lat, res, dep);
        checkOutput("full_80_lat", lat, 5);
        checkOutput("full_80_outp", res, 1);
        checkDepth("full_80_depth", dep, 4);
        applyStimulus(8'h7F, lat, res, dep);
        checkOutput("full_7f_lat", lat, 5);
        checkOutput("full_7f_outp", res, 0);
        cfgWrite(1, mk(1, 0, 1));
        applyStimulus(8'h00, lat, res, dep);
        checkOutput("early_leaf_lat", lat, 2);
        checkOutput("early_leaf_outp", res, 1);

        out_ready = 1'b0;
        in_valid  = 1'b1;
        inp       = 8'h80;
        @(negedge clk);
        in_valid = 1'b0;
        waitValid(lat);
        checkOutput("bp_lat", lat, 5);
        for (int k = 0; k < 10; k++) begin
            in_valid = k[0];
            inp      = 8'h00;
            @(negedge clk);
            checkOutput("bp_out_valid", int'(out_valid), 1);
            checkOutput("bp_outp", int'(outp), 1);
            checkOutput("bp_in_ready", int'(in_ready), 0);
        end
        out_ready = 1'b1;
        in_valid  = 1'b1;
        inp       = 8'h00;
        @(negedge clk);
        checkOutput("handoff_out_valid", int'(out_valid), 0);
        checkOutput("handoff_in_ready", int'(in_ready), 1);
        @(negedge clk);
        in_valid = 1'b0;
        waitValid(lat);
        checkOutput("handoff_lat", lat, 2);
        checkOutput("handoff_outp", int'(outp), 1);
        @(negedge clk);

        in_valid = 1'b1;
        inp      = 8'h80;
        @(negedge clk);
        in_valid  = 1'b0;
        cfg_we    = 1'b1;
        cfg_addr  = 5'd30;
        cfg_wdata = mk(1, 0, 0);
        @(negedge clk);
        cfg_we = 1'b0;
        checkOutput("walk_cfg_err", int'(cfg_err), 1);
        waitValid(lat);
        checkOutput("walk_cfg_outp", int'(outp), 1);
        @(negedge clk);
        cfgWrite(31, mk(1, 0, 0));
        checkOutput("addr31_cfg_err", int'(cfg_err), 1);
        applyStimulus(8'h80, lat, res, dep);
        checkOutput("after_err_lat", lat, 5);
        checkOutput("after_err_outp", res, 1);

        out_ready = 1'b0;
        in_valid  = 1'b1;
        inp       = 8'h80;
        @(negedge clk);
        in_valid = 1'b0;
        waitValid(lat);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("done_rst_out_valid", int'(out_valid), 0);
        checkOutput("done_rst_in_ready", int'(in_ready), 1);
        checkOutput("done_rst_outp", int'(outp), 0);
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        applyStimulus(8'h80, lat, res, dep);
        checkOutput("tbl_reinit_lat", lat, 1);
        checkOutput("tbl_reinit_outp", res, 0);

        cfgWrite(0, mk(0, 7, 0));
        in_valid = 1'b1;
        inp      = 8'h80;
        @(negedge clk);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checkOutput("walk_rst_in_ready", int'(in_ready), 1);
        checkOutput("walk_rst_out_valid", int'(out_valid), 0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(8'h80, lat, res, dep);
        checkOutput("walk_rst_lat", lat, 1);
        checkOutput("walk_rst_outp", res, 0);

        cfg_we    = 1'b1;
        cfg_addr  = 5'd0;
        cfg_wdata = mk(1, 0, 1);
        in_valid  = 1'b1;
        inp       = 8'h00;
        @(negedge clk);
        cfg_we   = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        checkOutput("same_cycle_valid", int'(out_valid), 1);
        checkOutput("same_cycle_outp", int'(outp), 1);
        @(negedge clk);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
